// File: rtl/gf2m163_pkg.sv
// Shared field constants, FSM state type and GF(2^163) arithmetic helpers
// for the LD-to-affine conversion stage.
package gf2m163_pkg;

    localparam int unsigned M = 163;
    // f(x) = x^163 + x^7 + x^6 + x^3 + 1
    localparam logic [M:0] F_POLY = {1'b1, 155'd0, 8'hC9};
    localparam logic [M-1:0] F_RED = F_POLY[M-1:0];

    typedef enum logic [2:0] {
        IDLE,
        INV_REQ,
        INV_REL,
        MUL_X,
        MUL_Y,
        OUT
    } state_e;

    // MSB-first interleaved multiply: shift, reduce, conditionally add.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        r = '0;
        for (int i = M - 1; i >= 0; i--) begin
            r = {r[M-2:0], 1'b0} ^ (r[M-1] ? F_RED : '0);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] a);
        logic [2*M-2:0] t;
        t = '0;
        for (int i = 0; i < M; i++) t[2*i] = a[i];
        for (int i = 2 * M - 2; i >= M; i--) begin
            if (t[i]) t = t ^ ((2*M-1)'(F_POLY) << (i - M));
        end
        return t[M-1:0];
    endfunction

endpackage

// File: rtl/gf2m_inv163.sv
// Itoh-Tsujii inverter over GF(2^163) with a start/done handshake.
// Chain 1,2,4,5,10,20,40,80,81,162 builds a^(2^162-1); one final square gives a^-1.
module gf2m_inv163
    import gf2m163_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] a,
    output logic         done,
    output logic [M-1:0] inv
);

    typedef enum logic [2:0] {
        I_IDLE,
        I_SQR,
        I_MUL,
        I_FIN,
        I_DONE
    } inv_state_e;

    localparam logic [3:0] LAST_STEP = 4'd8;

    inv_state_e   st_q, st_d;
    logic [M-1:0] beta_q, beta_d, a_q, a_d, save_q, save_d;
    logic [7:0]   k_q, k_d, cnt_q, cnt_d;
    logic [3:0]   step_q, step_d, step_nx;
    logic [M-1:0] sqr_r, mul_r;
    logic         nx_inc;

    assign sqr_r   = gf_sqr(beta_q);
    assign mul_r   = gf_mul(beta_q, save_q);
    assign step_nx = step_q + 4'd1;
    // Steps 2 and 7 of the chain are +1 steps; the rest are doublings.
    assign nx_inc  = (step_nx == 4'd2) || (step_nx == 4'd7);

    always_comb begin
        st_d   = st_q;
        beta_d = beta_q;
        a_d    = a_q;
        save_d = save_q;
        k_d    = k_q;
        cnt_d  = cnt_q;
        step_d = step_q;
        unique case (st_q)
            I_IDLE: begin
                if (start) begin
                    beta_d = a;
                    a_d    = a;
                    save_d = a;
                    cnt_d  = 8'd1;
                    k_d    = 8'd2;
                    step_d = 4'd0;
                    st_d   = I_SQR;
                end
            end
            I_SQR: begin
                beta_d = sqr_r;
                cnt_d  = cnt_q - 8'd1;
                if (cnt_q == 8'd1) st_d = I_MUL;
            end
            I_MUL: begin
                beta_d = mul_r;
                if (step_q == LAST_STEP) begin
                    st_d = I_FIN;
                end else begin
                    step_d = step_nx;
                    save_d = nx_inc ? a_q : mul_r;
                    cnt_d  = nx_inc ? 8'd1 : k_q;
                    k_d    = nx_inc ? k_q + 8'd1 : {k_q[6:0], 1'b0};
                    st_d   = I_SQR;
                end
            end
            I_FIN: begin
                beta_d = sqr_r;
                st_d   = I_DONE;
            end
            I_DONE: begin
                if (!start) st_d = I_IDLE;
            end
            default: st_d = I_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= I_IDLE;
            beta_q <= '0;
            a_q    <= '0;
            save_q <= '0;
            k_q    <= '0;
            cnt_q  <= '0;
            step_q <= '0;
        end else begin
            st_q   <= st_d;
            beta_q <= beta_d;
            a_q    <= a_d;
            save_q <= save_d;
            k_q    <= k_d;
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

    assign done = (st_q == I_DONE);
    assign inv  = beta_q;

endmodule

// File: rtl/gf2m_mult163.sv
// Combinational GF(2^163) multiplier; callers hold operands for a multicycle window.
module gf2m_mult163
    import gf2m163_pkg::*;
(
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);

    assign p = gf_mul(a, b);

endmodule

// File: rtl/squerer_163.sv
// Combinational GF(2^163) squarer (bit spread followed by reduction).
module squerer_163
    import gf2m163_pkg::*;
(
    input  logic [M-1:0] a,
    output logic [M-1:0] c
);

    assign c = gf_sqr(a);

endmodule

// File: rtl/gf2m_ld2affine_163.sv
// Lopez-Dahab projective (X,Z,Y) to affine over GF(2^163): x = X/Z, y = Y/Z^2.
// Define GF2M_LD2AFF_INF_DETECT_EN to short-cut Z==0 to an inf result without inverting.
module gf2m_ld2affine_163
    import gf2m163_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] X_in,
    input  logic [M-1:0] Y_in,
    input  logic [M-1:0] Z_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] x_out,
    output logic [M-1:0] y_out,
    output logic         inf
);

    localparam int unsigned CntW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
    localparam logic [CntW-1:0] CNT_LAST = CntW'(MUL_LAT);

    state_e        state_q, state_d;
    logic [M-1:0]  x_q, x_d, y_q, y_d, z_q, z_d, zinv_q, zinv_d;
    logic [M-1:0]  xo_q, xo_d, yo_q, yo_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic          inv_rst, inv_start, inv_done;
    logic [M-1:0]  inv_res, zinv_sq, mul_a, mul_b, mul_res;

    // Holding the inverter in reset with the block means a reset aborts any inversion.
    assign inv_rst   = ~rst_n;
    assign inv_start = (state_q == INV_REQ);
    assign mul_a     = (state_q == MUL_Y) ? y_q : x_q;
    assign mul_b     = (state_q == MUL_Y) ? zinv_sq : zinv_q;

    gf2m_inv163 u_inv (
        .clk   (clk),
        .rst   (inv_rst),
        .start (inv_start),
        .a     (z_q),
        .done  (inv_done),
        .inv   (inv_res)
    );

    gf2m_mult163 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_res)
    );

    squerer_163 u_sqr (
        .a (zinv_q),
        .c (zinv_sq)
    );

`ifdef GF2M_LD2AFF_INF_DETECT_EN
    logic inf_q, inf_d;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zinv_d  = zinv_q;
        cnt_d   = cnt_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
`ifdef GF2M_LD2AFF_INF_DETECT_EN
        inf_d   = inf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = X_in;
                    y_d     = Y_in;
                    z_d     = Z_in;
                    state_d = INV_REQ;
`ifdef GF2M_LD2AFF_INF_DETECT_EN
                    inf_d   = 1'b0;
                    if (Z_in == '0) begin
                        xo_d    = '0;
                        yo_d    = '0;
                        inf_d   = 1'b1;
                        state_d = OUT;
                    end
`endif
                end
            end
            INV_REQ: begin
                if (inv_done) begin
                    zinv_d  = inv_res;
                    state_d = INV_REL;
                end
            end
            INV_REL: begin
                if (!inv_done) begin
                    cnt_d   = '0;
                    state_d = MUL_X;
                end
            end
            MUL_X: begin
                if (cnt_q == CNT_LAST) begin
                    xo_d    = mul_res;
                    cnt_d   = '0;
                    state_d = MUL_Y;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MUL_Y: begin
                if (cnt_q == CNT_LAST) begin
                    yo_d    = mul_res;
                    cnt_d   = '0;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zinv_q  <= '0;
            cnt_q   <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zinv_q  <= zinv_d;
            cnt_q   <= cnt_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
        end
    end

`ifdef GF2M_LD2AFF_INF_DETECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inf_q <= 1'b0;
        else        inf_q <= inf_d;
    end
    assign inf = inf_q;
`else
    assign inf = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign x_out     = xo_q;
    assign y_out     = yo_q;

endmodule

// File: tb/tb_gf2m_ld2affine_163.sv
// Scoreboard bench for gf2m_ld2affine_163 against a schoolbook/Fermat field model.
module tb_gf2m_ld2affine_163;

    localparam logic [163:0] POLY = {1'b1, 155'd0, 8'hC9};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [162:0] X_in = '0, Y_in = '0, Z_in = '0;
    logic         in_ready, out_valid, inf;
    logic [162:0] x_out, y_out;

    int checks = 0;
    int errors = 0;
    bit bp_en = 1'b0;
    logic prev_start = 1'b0;

    logic [162:0] exp_x[$];
    logic [162:0] exp_y[$];
    logic         exp_inf[$];

    gf2m_ld2affine_163 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X_in      (X_in),
        .Y_in      (Y_in),
        .Z_in      (Z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .inf       (inf)
    );

    always #5 clk = ~clk;

    // Carry-less product, then polynomial long division by f(x).
    function automatic logic [162:0] ref_mul(input logic [162:0] a, input logic [162:0] b);
        logic [324:0] p;
        p = '0;
        for (int i = 0; i < 163; i++) if (b[i]) p = p ^ ({162'd0, a} << i);
        for (int i = 324; i >= 163; i--) if (p[i]) p = p ^ ({161'd0, POLY} << (i - 163));
        return p[162:0];
    endfunction

    // Fermat: a^-1 = a^(2^163-2) = product of a^(2^j), j=1..162 (0 maps to 0).
    function automatic logic [162:0] ref_inv(input logic [162:0] a);
        logic [162:0] r, t;
        r = 163'd1;
        t = a;
        for (int j = 0; j < 162; j++) begin
            t = ref_mul(t, t);
            r = ref_mul(r, t);
        end
        return r;
    endfunction

    function automatic logic [162:0] rand163();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[162:0];
    endfunction

    task automatic check(input string name, input logic [162:0] act, input logic [162:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic send(input logic [162:0] xv, input logic [162:0] yv, input logic [162:0] zv,
                        input logic [162:0] ex, input logic [162:0] ey, input logic ei,
                        input bit keep);
        int n = 0;
        in_valid = 1'b1;
        X_in = xv;
        Y_in = yv;
        Z_in = zv;
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1");
            in_valid = 1'b0;
            return;
        end
        exp_x.push_back(ex);
        exp_y.push_back(ey);
        exp_inf.push_back(ei);
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [162:0] xv, input logic [162:0] yv,
                              input logic [162:0] zv, input bit keep);
        logic [162:0] zi;
        logic ei;
        zi = ref_inv(zv);
`ifdef GF2M_LD2AFF_INF_DETECT_EN
        ei = (zv == '0);
`else
        ei = 1'b0;
`endif
        send(xv, yv, zv, ref_mul(xv, zi), ref_mul(yv, ref_mul(zi, zi)), ei, keep);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_x.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_x.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending %0d, expected 0", exp_x.size());
            exp_x.delete();
            exp_y.delete();
            exp_inf.delete();
        end
    endtask

    // Output monitor: every accepted result is popped and compared.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_x.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: x=%h y=%h, expected no output", x_out, y_out);
            end else begin
                logic [162:0] ex, ey;
                logic ei;
                ex = exp_x.pop_front();
                ey = exp_y.pop_front();
                ei = exp_inf.pop_front();
                if (x_out !== ex || y_out !== ey || inf !== ei) begin
                    errors++;
                    $display("FAIL result: x=%h y=%h inf=%b, expected x=%h y=%h inf=%b",
                             x_out, y_out, inf, ex, ey, ei);
                end
            end
        end
    end

    // A new inversion request must never start while the inverter still signals done.
    always @(negedge clk) begin
        if (rst_n && dut.inv_start && !prev_start) begin
            checks++;
            if (dut.inv_done) begin
                errors++;
                $display("FAIL inv_start_rise: inv_done got 1, expected 0");
            end
        end
        prev_start = dut.inv_start;
    end

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [162:0] xr, yr, zr;
        int n;

        repeat (3) @(negedge clk);
        check("reset_in_ready", 163'(in_ready), 163'd1);
        check("reset_out_valid", 163'(out_valid), 163'd0);
        check("reset_x_out", x_out, 163'd0);
        check("reset_y_out", y_out, 163'd0);
        check("reset_inf", 163'(inf), 163'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Z=1 and Z=x: hand-derived results.
        send(163'd5, 163'd3, 163'd1, 163'd5, 163'd3, 1'b0, 1'b0);
        drain();
        send(163'd2, 163'd4, 163'd2, 163'd1, 163'd1, 1'b0, 1'b0);
        drain();

        // Z=0: both outputs zero; inf only when detection is built in.
`ifdef GF2M_LD2AFF_INF_DETECT_EN
        send(163'd5, 163'd3, 163'd0, 163'd0, 163'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("inf_latency_out_valid", 163'(out_valid), 163'd1);
`else
        send(163'd5, 163'd3, 163'd0, 163'd0, 163'd0, 1'b0, 1'b0);
`endif
        drain();

        // Reset in the middle of the inversion: nothing may come out.
        send(163'd2, 163'd4, 163'd2, 163'd1, 163'd1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("busy_in_ready", 163'(in_ready), 163'd0);
        rst_n = 1'b0;
        exp_x.delete();
        exp_y.delete();
        exp_inf.delete();
        #1;
        check("midreset_out_valid", 163'(out_valid), 163'd0);
        check("midreset_in_ready", 163'(in_ready), 163'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(163'd2, 163'd4, 163'd2, 163'd1, 163'd1, 1'b0, 1'b0);
        drain();

        // Back-to-back with in_valid held high.
        out_ready = 1'b1;
        send_model(rand163(), rand163(), rand163(), 1'b1);
        send_model(rand163(), rand163(), rand163(), 1'b0);
        drain();

        // Stall in OUT for 10 cycles.
        out_ready = 1'b0;
        send_model(rand163(), rand163(), rand163(), 1'b0);
        n = 0;
        while (!out_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (exp_x.size() == 0 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                x_out !== exp_x[0] || y_out !== exp_y[0]) begin
                errors++;
                $display("FAIL stall_hold: out_valid=%b in_ready=%b x=%h, expected 1 0 and held x",
                         out_valid, in_ready, x_out);
            end
        end
        out_ready = 1'b1;
        drain();

        // Randomised operands with occasional Z=0 and random backpressure.
        bp_en = 1'b1;
        for (int t = 0; t < 16; t++) begin
            xr = rand163();
            yr = rand163();
            zr = ($urandom_range(0, 5) == 0) ? 163'd0 : rand163();
            send_model(xr, yr, zr, ($urandom_range(0, 1) == 1));
        end
        in_valid = 1'b0;
        drain();
        bp_en = 1'b0;
        #2;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
